img_mem_xfer_ctrl: RTL and testbench

- Block-transfer sequencer for the 10-lane image DRAM (18-bit address, 16-bit pixel, one shared write enable).
- On a start pulse it walks a pixel region 10 lanes at a time. For each chunk it reads through all lanes, transforms the pixels and writes them to a destination region.
- Supported transforms: copy, invert, fill, threshold.
- Sits between the processor's image-command interface and the DRAM lane ports. It owns those ports while busy.

---
 rtl/img_mem_xfer_ctrl_if.sv | 31 +++
 rtl/img_mem_xfer_ctrl.sv | 130 +++++++++++++
 tb/tb_img_mem_xfer_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/img_mem_xfer_ctrl_if.sv
// Image-command and DRAM lane bundle for the block-transfer sequencer.
// master = the sequencer; slave = processor plus DRAM side.
interface img_mem_xfer_ctrl_if #(
   parameter int AW    = 18,
   parameter int DW    = 16,
   parameter int LANES = 10
);
   logic                  start;
   logic [1:0]            mode;
   logic [AW-1:0]         src_base;
   logic [AW-1:0]         dst_base;
   logic [AW-1:0]         length;
   logic [DW-1:0]         fill_val;
   logic [DW-1:0]         thresh;
   logic                  busy;
   logic                  done;
   logic                  mem_we;
   logic [LANES*AW-1:0]   mem_a;
   logic [LANES*DW-1:0]   mem_wd;
   logic [LANES*DW-1:0]   mem_rd;

   modport master (
      input  start, mode, src_base, dst_base, length, fill_val, thresh, mem_rd,
      output busy, done, mem_we, mem_a, mem_wd
   );

   modport slave (
      output start, mode, src_base, dst_base, length, fill_val, thresh, mem_rd,
      input  busy, done, mem_we, mem_a, mem_wd
   );
endinterface

// File: rtl/img_mem_xfer_ctrl.sv
// Walks a pixel region LANES at a time: READ+WRITE per chunk (WRITE only for fill), then DONE.
// Done arrives 2*ceil(len/LANES)+1 cycles after start (fill: ceil+1); no backpressure, start ignored while busy.
module img_mem_xfer_ctrl #(
   parameter int AW    = 18,
   parameter int DW    = 16,
   parameter int LANES = 10
) (
   input  logic                clk,
   input  logic                rst_n,
   img_mem_xfer_ctrl_if.master bus
);
   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

   localparam logic [1:0] M_COPY = 2'b00;
   localparam logic [1:0] M_INV  = 2'b01;
   localparam logic [1:0] M_FILL = 2'b10;

   state_t          state_q, state_d;
   logic [1:0]      mode_q, mode_d;
   logic [AW-1:0]   src_q, src_d;
   logic [AW-1:0]   dst_q, dst_d;
   logic [AW-1:0]   off_q, off_d;
   logic [AW-1:0]   rem_q, rem_d;
   logic [DW-1:0]   fill_q, fill_d;
   logic [DW-1:0]   thr_q, thr_d;
   logic [DW-1:0]   buf_q [LANES];
   logic [DW-1:0]   buf_d [LANES];

   logic [AW-1:0]       chunk;
   logic [LANES*AW-1:0] mem_a_c;
   logic [LANES*DW-1:0] mem_wd_c;

   assign chunk = (rem_q < AW'(LANES)) ? rem_q : AW'(LANES);

   function automatic logic [DW-1:0] xform(input logic [DW-1:0] px);
      logic [DW-1:0] r;
      case (mode_q)
         M_COPY:  r = px;
         M_INV:   r = ~px;
         M_FILL:  r = fill_q;
         default: r = (px >= thr_q) ? DW'(16'h00FF) : '0;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         mode_q  <= '0;
         src_q   <= '0;
         dst_q   <= '0;
         off_q   <= '0;
         rem_q   <= '0;
         fill_q  <= '0;
         thr_q   <= '0;
         for (int i = 0; i < LANES; i++) buf_q[i] <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         off_q   <= off_d;
         rem_q   <= rem_d;
         fill_q  <= fill_d;
         thr_q   <= thr_d;
         for (int i = 0; i < LANES; i++) buf_q[i] <= buf_d[i];
      end
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      src_d   = src_q;
      dst_d   = dst_q;
      off_d   = off_q;
      rem_d   = rem_q;
      fill_d  = fill_q;
      thr_d   = thr_q;
      for (int i = 0; i < LANES; i++) buf_d[i] = buf_q[i];

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               mode_d  = bus.mode;
               src_d   = bus.src_base;
               dst_d   = bus.dst_base;
               fill_d  = bus.fill_val;
               thr_d   = bus.thresh;
               off_d   = '0;
               rem_d   = bus.length;
               if (bus.length == '0)        state_d = S_DONE;
               else if (bus.mode == M_FILL) state_d = S_WRITE;
               else                         state_d = S_READ;
            end
         end
         S_READ: begin
            for (int i = 0; i < LANES; i++) buf_d[i] = bus.mem_rd[i*DW +: DW];
            state_d = S_WRITE;
         end
         S_WRITE: begin
            off_d = off_q + chunk;
            rem_d = rem_q - chunk;
            if (rem_q == chunk)        state_d = S_DONE;
            else if (mode_q == M_FILL) state_d = S_WRITE;
            else                       state_d = S_READ;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Inactive lanes mirror lane 0 so the shared write enable only rewrites an in-region pixel.
   always_comb begin
      mem_a_c  = '0;
      mem_wd_c = '0;
      for (int i = 0; i < LANES; i++) begin
         if (state_q == S_READ) begin
            mem_a_c[i*AW +: AW] = src_q + off_q + ((AW'(i) < chunk) ? AW'(i) : '0);
         end else if (state_q == S_WRITE) begin
            mem_a_c[i*AW +: AW]  = dst_q + off_q + ((AW'(i) < chunk) ? AW'(i) : '0);
            mem_wd_c[i*DW +: DW] = xform((AW'(i) < chunk) ? buf_q[i] : buf_q[0]);
         end
      end
   end

   assign bus.busy   = (state_q != S_IDLE);
   assign bus.done   = (state_q == S_DONE);
   assign bus.mem_we = (state_q == S_WRITE);
   assign bus.mem_a  = mem_a_c;
   assign bus.mem_wd = mem_wd_c;
endmodule

// File: tb/tb_img_mem_xfer_ctrl.sv
// Bench for img_mem_xfer_ctrl: DRAM model, per-cycle transaction-level model, directed tests.
module tb_img_mem_xfer_ctrl;
   localparam int AW    = 18;
   localparam int DW    = 16;
   localparam int LANES = 10;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   img_mem_xfer_ctrl_if #(.AW(AW), .DW(DW), .LANES(LANES)) bif ();

   img_mem_xfer_ctrl #(.AW(AW), .DW(DW), .LANES(LANES)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif.master)
   );

   // DRAM: combinational read per lane, written by the DUT or by the bench preload port
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic          pre_we = 1'b0;
   logic [AW-1:0] pre_a  = '0;
   logic [DW-1:0] pre_d  = '0;

   always @(posedge clk) begin
      if (pre_we) mem[pre_a] <= pre_d;
      else if (bif.mem_we)
         for (int i = 0; i < LANES; i++) mem[bif.mem_a[i*AW +: AW]] <= bif.mem_wd[i*DW +: DW];
   end

   always_comb begin
      bif.mem_rd = '0;
      for (int i = 0; i < LANES; i++) bif.mem_rd[i*DW +: DW] = mem[bif.mem_a[i*AW +: AW]];
   end

   typedef struct {
      logic                busy, done, we, chk_a, chk_wd;
      logic [LANES*AW-1:0] a;
      logic [LANES*DW-1:0] wd;
   } exp_t;

   exp_t          exp_q [$];
   logic [DW-1:0] ref_mem [int];
   int            n_cmp  = 0;
   int            n_fail = 0;

   task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_cmp++;
         if (bif.busy !== e.busy || bif.done !== e.done || bif.mem_we !== e.we ||
             (e.chk_a && bif.mem_a !== e.a) || (e.chk_wd && bif.mem_wd !== e.wd)) begin
            n_fail++;
            $display("FAIL cycle @%0t: got busy=%b done=%b we=%b a=%h wd=%h want busy=%b done=%b we=%b a=%h wd=%h",
                     $time, bif.busy, bif.done, bif.mem_we, bif.mem_a, bif.mem_wd,
                     e.busy, e.done, e.we, e.a, e.wd);
         end
      end
   end

   // Transaction-level model: one expected entry per cycle after the start edge
   task automatic build_exp(input logic [1:0] md, input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input int len, input logic [DW-1:0] fv, input logic [DW-1:0] th);
      exp_t          e;
      int            off = 0;
      int            rem = len;
      logic [AW-1:0] ad;
      logic [DW-1:0] v [LANES];
      while (rem > 0) begin
         int ch = (rem < LANES) ? rem : LANES;
         for (int i = 0; i < LANES; i++) begin
            int li = (i < ch) ? i : 0;
            ad = s + AW'(off) + AW'(li);
            case (md)
               2'b00:   v[i] = ref_mem[int'(ad)];
               2'b01:   v[i] = ~ref_mem[int'(ad)];
               2'b10:   v[i] = fv;
               default: v[i] = (ref_mem[int'(ad)] >= th) ? 16'h00FF : 16'h0000;
            endcase
         end
         if (md != 2'b10) begin
            e = '{busy: 1, done: 0, we: 0, chk_a: 1, chk_wd: 0, a: '0, wd: '0};
            for (int i = 0; i < LANES; i++) e.a[i*AW +: AW] = s + AW'(off) + AW'((i < ch) ? i : 0);
            exp_q.push_back(e);
         end
         e = '{busy: 1, done: 0, we: 1, chk_a: 1, chk_wd: 1, a: '0, wd: '0};
         for (int i = 0; i < LANES; i++) begin
            e.a[i*AW +: AW]  = d + AW'(off) + AW'((i < ch) ? i : 0);
            e.wd[i*DW +: DW] = v[i];
         end
         exp_q.push_back(e);
         for (int i = 0; i < ch; i++) begin
            ad = d + AW'(off) + AW'(i);
            ref_mem[int'(ad)] = v[i];
         end
         off += ch;
         rem -= ch;
      end
      exp_q.push_back('{busy: 1, done: 1, we: 0, chk_a: 0, chk_wd: 0, a: '0, wd: '0});
      exp_q.push_back('{busy: 0, done: 0, we: 0, chk_a: 1, chk_wd: 1, a: '0, wd: '0});
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      #1;
      pre_we = 1'b1;
      pre_a  = a;
      pre_d  = d;
      ref_mem[int'(a)] = d;
   endtask

   task automatic run_xfer(input logic [1:0] md, input logic [AW-1:0] s, input logic [AW-1:0] d,
                           input int len, input logic [DW-1:0] fv, input logic [DW-1:0] th,
                           input bit poke, output int lat, output int wes, output int rds,
                           output logic [LANES*AW-1:0] ra);
      lat = -1; wes = 0; rds = 0; ra = '0;
      @(negedge clk);
      #1;
      pre_we = 1'b0;
      build_exp(md, s, d, len, fv, th);
      bif.start = 1'b1; bif.mode = md; bif.src_base = s; bif.dst_base = d;
      bif.length = AW'(len); bif.fill_val = fv; bif.thresh = th;
      @(posedge clk);
      #1;
      bif.start = 1'b0;
      for (int cyc = 1; cyc <= 100; cyc++) begin
         @(negedge clk);
         if (bif.done && lat < 0) lat = cyc;
         if (bif.mem_we) wes++;
         if (bif.busy && !bif.mem_we && !bif.done) begin
            if (rds == 0) ra = bif.mem_a;
            rds++;
         end
         if (poke && cyc == 2) begin
            #1;
            bif.start = 1'b1; bif.mode = 2'b10; bif.dst_base = 18'd700;
            bif.length = 18'd3; bif.fill_val = 16'hBEEF;
         end
         if (poke && cyc == 3) begin
            #1;
            bif.start = 1'b0;
         end
         if (exp_q.size() == 0) break;
      end
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL timeout: got %0d entries pending want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      int lat, wes, rds;
      logic [LANES*AW-1:0] ra;
      bif.start = 1'b0; bif.mode = '0; bif.src_base = '0; bif.dst_base = '0;
      bif.length = '0; bif.fill_val = '0; bif.thresh = '0;

      #3;
      chk("rst_busy", 192'(bif.busy), 192'(0));
      chk("rst_done", 192'(bif.done), 192'(0));
      chk("rst_we",   192'(bif.mem_we), 192'(0));
      chk("rst_a",    192'(bif.mem_a), 192'(0));
      chk("rst_wd",   192'(bif.mem_wd), 192'(0));
      @(negedge clk);
      #1 rst_n = 1'b1;

      // copy 25 pixels
      for (int i = 0; i < 25; i++) preload(AW'(i), DW'(111 + i));
      preload(18'd125, 16'h5A5A);
      run_xfer(2'b00, 18'd0, 18'd100, 25, 16'h0, 16'h0, 1'b0, lat, wes, rds, ra);
      chk("copy_lat", 192'(lat), 192'(7));
      chk("copy_writes", 192'(wes), 192'(3));
      for (int i = 0; i < 25; i++) chk("copy_data", 192'(mem[100 + i]), 192'(111 + i));
      chk("copy_guard", 192'(mem[125]), 192'(16'h5A5A));

      // invert 10 pixels
      for (int i = 0; i < 10; i++) preload(AW'(i), 16'h00F0);
      run_xfer(2'b01, 18'd0, 18'd200, 10, 16'h0, 16'h0, 1'b0, lat, wes, rds, ra);
      chk("inv_reads", 192'(rds), 192'(1));
      chk("inv_writes", 192'(wes), 192'(1));
      chk("inv_lat", 192'(lat), 192'(3));
      for (int i = 0; i < 10; i++) chk("inv_data", 192'(mem[200 + i]), 192'(16'hFF0F));

      // fill 13 pixels
      run_xfer(2'b10, 18'd0, 18'd50, 13, 16'h0ABC, 16'h0, 1'b0, lat, wes, rds, ra);
      chk("fill_reads", 192'(rds), 192'(0));
      chk("fill_lat", 192'(lat), 192'(3));
      for (int i = 0; i < 13; i++) chk("fill_data", 192'(mem[50 + i]), 192'(16'h0ABC));

      // threshold at 100 on ramp 0,20,..,180
      for (int i = 0; i < 10; i++) preload(AW'(i), DW'(i * 20));
      run_xfer(2'b11, 18'd0, 18'd400, 10, 16'h0, 16'd100, 1'b0, lat, wes, rds, ra);
      for (int i = 0; i < 5; i++)  chk("thr_lo", 192'(mem[400 + i]), 192'(16'h0000));
      for (int i = 5; i < 10; i++) chk("thr_hi", 192'(mem[400 + i]), 192'(16'h00FF));

      // zero length
      run_xfer(2'b00, 18'd0, 18'd900, 0, 16'h0, 16'h0, 1'b0, lat, wes, rds, ra);
      chk("zero_lat", 192'(lat), 192'(1));
      chk("zero_writes", 192'(wes), 192'(0));

      // source wrapping past the top of the address space
      preload(18'h3FFFD, 16'h7000); preload(18'h3FFFE, 16'h7001); preload(18'h3FFFF, 16'h7002);
      preload(18'h00000, 16'h7003); preload(18'h00001, 16'h7004);
      run_xfer(2'b00, 18'h3FFFD, 18'd500, 5, 16'h0, 16'h0, 1'b0, lat, wes, rds, ra);
      chk("wrap_a0", 192'(ra[0*AW +: AW]), 192'(18'h3FFFD));
      chk("wrap_a2", 192'(ra[2*AW +: AW]), 192'(18'h3FFFF));
      chk("wrap_a3", 192'(ra[3*AW +: AW]), 192'(18'h00000));
      chk("wrap_a4", 192'(ra[4*AW +: AW]), 192'(18'h00001));
      for (int i = 0; i < 5; i++) chk("wrap_data", 192'(mem[500 + i]), 192'(16'h7000 + i));

      // start pulsed while busy is ignored
      for (int i = 0; i < 25; i++) preload(AW'(i), DW'(111 + i));
      preload(18'd700, 16'h1234);
      run_xfer(2'b00, 18'd0, 18'd600, 25, 16'h0, 16'h0, 1'b1, lat, wes, rds, ra);
      chk("poke_lat", 192'(lat), 192'(7));
      chk("poke_guard", 192'(mem[700]), 192'(16'h1234));
      for (int i = 0; i < 25; i++) chk("poke_data", 192'(mem[600 + i]), 192'(111 + i));

      // async reset during the second WRITE of a 25-pixel copy
      for (int i = 0; i < 5; i++) preload(AW'(320 + i), 16'hEEEE);
      @(negedge clk);
      #1;
      pre_we = 1'b0;
      bif.start = 1'b1; bif.mode = 2'b00; bif.src_base = 18'd0; bif.dst_base = 18'd300;
      bif.length = 18'd25;
      @(posedge clk);
      #1 bif.start = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid_we_pre", 192'(bif.mem_we), 192'(1));
      #1 rst_n = 1'b0;
      #1;
      chk("mid_we", 192'(bif.mem_we), 192'(0));
      chk("mid_busy", 192'(bif.busy), 192'(0));
      chk("mid_a", 192'(bif.mem_a), 192'(0));
      begin
         int dn = 0;
         repeat (4) begin
            @(negedge clk);
            if (bif.done) dn++;
         end
         #1 rst_n = 1'b1;
         repeat (4) begin
            @(negedge clk);
            if (bif.done) dn++;
         end
         chk("mid_no_done", 192'(dn), 192'(0));
      end
      for (int i = 0; i < 10; i++) chk("mid_chunk0", 192'(mem[300 + i]), 192'(111 + i));
      for (int i = 0; i < 5; i++)  chk("mid_chunk2", 192'(mem[320 + i]), 192'(16'hEEEE));
      for (int i = 0; i < 10; i++) ref_mem[300 + i] = DW'(111 + i);

      run_xfer(2'b00, 18'd0, 18'd800, 3, 16'h0, 16'h0, 1'b0, lat, wes, rds, ra);
      chk("post_lat", 192'(lat), 192'(3));
      for (int i = 0; i < 3; i++) chk("post_data", 192'(mem[800 + i]), 192'(111 + i));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end
endmodule
